// File: rtl/gbdt_node_mem_arb.sv
// Round-robin arbiter that shares the single-port tree-node SRAM among the tree-walk
// engines. A fixed-latency tag pipeline routes each read word back to the engine that issued it.
module gbdt_node_mem_arb #(
  parameter int NUM_REQ = 8,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int RD_LAT  = 2
) (
  input  logic                      i_gbdt_clk,
  input  logic                      i_gbdt_rst,
  input  logic                      i_enable,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic                      o_mem_cs,
  output logic                      o_mem_oe,
  output logic [ADDR_W-1:0]         o_mem_addr,
  input  logic [DATA_W-1:0]         i_mem_rdata,
  output logic [NUM_REQ-1:0]        o_rsp_valid,
  output logic [DATA_W-1:0]         o_rsp_data,
  output logic                      o_busy
);
  localparam int                 IDX_W   = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0]   IDX_ONE = IDX_W'(1);
  localparam logic [NUM_REQ-1:0] GNT_ONE = NUM_REQ'(1);

  logic [IDX_W-1:0]   r_ptr;
  logic [RD_LAT-1:0]  r_tag_vld;
  logic [NUM_REQ-1:0] r_tag_id [RD_LAT];

  logic               w_grant;
  logic               w_found;
  logic               w_hit;
  logic [IDX_W-1:0]   w_idx;
  logic [IDX_W-1:0]   w_winner;

  // Rotating scan from the priority pointer; the index wraps because NUM_REQ is a power of 2.
  always_comb begin
    w_found  = 1'b0;
    w_hit    = 1'b0;
    w_idx    = '0;
    w_winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx    = r_ptr + IDX_W'(k);
      w_hit    = i_req[w_idx] & ~w_found;
      w_winner = w_hit ? w_idx : w_winner;
      w_found  = w_found | w_hit;
    end
  end

  assign w_grant     = ~i_gbdt_rst & i_enable & (|i_req);
  assign o_gnt       = w_grant ? (GNT_ONE << w_winner) : '0;
  assign o_mem_cs    = w_grant;
  assign o_mem_oe    = w_grant;
  assign o_mem_addr  = w_grant ? i_req_addr[int'(w_winner) * ADDR_W +: ADDR_W] : '0;
  assign o_rsp_valid = (~i_gbdt_rst & r_tag_vld[RD_LAT-1]) ? r_tag_id[RD_LAT-1] : '0;
  assign o_rsp_data  = i_mem_rdata;
  assign o_busy      = ~i_gbdt_rst & ((|r_tag_vld) | (i_enable & (|i_req)));

  // Priority pointer moves one past each winner so the winner becomes lowest priority.
  always_ff @(posedge i_gbdt_clk) begin
    if (i_gbdt_rst) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= w_winner + IDX_ONE;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // Tag pipeline tracks {valid, one-hot owner}, aligned with the SRAM read latency.
  always_ff @(posedge i_gbdt_clk) begin
    if (i_gbdt_rst) begin
      r_tag_vld <= '0;
      for (int s = 0; s < RD_LAT; s++) begin
        r_tag_id[s] <= '0;
      end
    end else begin
      r_tag_vld[0] <= w_grant;
      r_tag_id[0]  <= o_gnt;
      for (int s = 1; s < RD_LAT; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_id[s]  <= r_tag_id[s-1];
      end
    end
  end
endmodule

// File: doc/gbdt_node_mem_arb.md
Name: gbdt_node_mem_arb

Overview:
- Round-robin arbiter that shares the single-port tree-node SRAM between the 8 per-class tree-walk engines during a round's evaluation phase.
- Grants at most one read per cycle and drives the SRAM cs/oe/address.
- Tracks in-flight reads through a fixed-latency tag pipeline and returns each read word to the engine that issued it.
- Sits between the round controller (which supplies enable) and the node memory.

Parameters:
- NUM_REQ, 8, number of requesting engines (≥2, power of 2).
- ADDR_W, 12, node-memory address width.
- DATA_W, 32, node-memory word width.
- RD_LAT, 2, SRAM read latency in cycles from cs/addr to valid rdata (1..4).

Ports:
- gbdt_clk  in  1  clock.
- gbdt_rst  in  1  synchronous, active-high reset.
- enable  in  1  round-phase enable from the controller; arbitration only while high.
- req  in  NUM_REQ  per-engine read request; held until granted.
- req_addr  in  NUM_REQ*ADDR_W  per-engine address; slice i = [i*ADDR_W +: ADDR_W].
- gnt  out  NUM_REQ  one-hot grant; combinational, same cycle as the winning req.
- mem_cs  out  1  SRAM chip select for this cycle's read.
- mem_oe  out  1  SRAM output enable; equals mem_cs.
- mem_addr  out  ADDR_W  address of the granted requester; 0 when mem_cs is low.
- mem_rdata  in  DATA_W  SRAM read data, valid RD_LAT cycles after mem_cs.
- rsp_valid  out  NUM_REQ  one-hot response strobe to the owning engine.
- rsp_data  out  DATA_W  response word; equals mem_rdata; meaningful only when rsp_valid is nonzero.
- busy  out  1  high while any read is in flight or any req is pending with enable high.

Behaviour:
- Reset (sync, gbdt_rst=1 at a clock edge):
  - Priority pointer is set to 0, so engine 0 has highest priority.
  - Tag pipeline is cleared, so rsp_valid=0 on the following cycle.
  - Combinational outputs (gnt, mem_cs, mem_oe, mem_addr, busy) are forced to 0 while gbdt_rst is high.
- Arbitration, cycle T, when enable=1 and req≠0:
  - The winner is the first set req bit scanning ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1 (modulo NUM_REQ).
  - gnt[winner]=1, mem_cs=mem_oe=1, mem_addr=req_addr slice of the winner, all in cycle T.
  - At the edge ending T, ptr ← (winner+1) mod NUM_REQ (wrap from NUM_REQ-1 to 0).
- No grant (enable=0 or req=0): gnt=0, mem_cs=0, mem_addr=0, ptr holds.
- Starvation bound: a continuously asserted req is granted within NUM_REQ cycles of enabled arbitration.
- Requester rule:
  - Hold req and address stable until gnt.
  - The cycle after gnt, the engine may keep req high with a new address, which is treated as a new request.
  - The arbiter never grants twice in one cycle.
- Response path:
  - Tag pipeline of RD_LAT stages, each holding {valid, one-hot id}.
  - Stage 0 loads {mem_cs, gnt} every cycle; the stages shift every cycle.
  - rsp_valid = final stage id masked by its valid, so a grant in cycle T gives rsp_valid[winner]=1 in cycle T+RD_LAT.
  - rsp_data = mem_rdata (pass-through, no register).
  - Throughput: one response per cycle; back-to-back grants give back-to-back responses in grant order.
- enable falling with reads in flight:
  - No new grants.
  - In-flight reads still complete and deliver rsp_valid.
  - busy stays high until the last response cycle and is low from the next cycle.
- Reset mid-operation: in-flight reads are discarded with no rsp_valid for them; ptr returns to 0.
- Simultaneous events:
  - A request asserted in the same cycle that ptr moves onto it is granted that cycle if it is first in scan order.
  - A response delivery and a new grant to the same engine in one cycle are both legal.

Test Plan:
- Reset, then enable=1, req=8'hFF held, addrs i*16 → gnt sequence 0,1,…,7,0; mem_addr 0x000,0x010,…,0x070; rsp_valid[i] 2 cycles after each grant; no idle cycles.
- ptr=3 (after granting engine 2), req=8'b1000_0101 → grants engine 7, then 0, then 2.
- Single req[5]=1, addr=0x2A5, SRAM model returns 0xDEAD_BEEF → gnt[5] in cycle T; rsp_valid=8'h20 and rsp_data=0xDEAD_BEEF at T+2; nothing else.
- Three grants, then enable drops at T+3 → gnt=0 from T+3; three responses complete; busy falls after the last rsp_valid.
- gbdt_rst pulsed one cycle after a grant → no rsp_valid for that grant; next arbitration starts at engine 0.
- RD_LAT=1 and RD_LAT=4 builds with req=8'hFF → responses at exactly T+1 and T+4 respectively, one-hot ids matching grant order.
